// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The lights/delay FSM also imports CLK_PER_MS_DEFAULT, so both blocks agree
// on the length of one millisecond tick.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int CLK_PER_MS_DEFAULT = 50000;

  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/reaction_timer_bcd_digit.sv
// One BCD decade counter, wraps 9 -> 0 and raises co on that wrap.
// Latency: q updates on the clk edge after inc; co is combinational.
// Backpressure: none, inc is applied every cycle it is high.
//
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (carry in), q[3:0] (digit value), co (carry out = inc & q==9).
module bcd_digit
  import reaction_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       co
);

  assign co = inc & (q == BCD_NINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == BCD_NINE) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Measures reaction time in ms from a start_timer rising edge to a stop key press.
// Latency: pin to event 3 clk; done is registered one cycle after the ending event.
// Backpressure: none; start during RUN and presses outside RUN are dropped.
//
// Ports: clk, rst_n (async active-low), start_timer (level from lights FSM),
//        stop_n (raw active-low button), bcd (DIGITS BCD digits, digit 0 in [3:0]),
//        busy (measuring), done (1-cycle end pulse), overflow (sticky until restart).
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEFAULT,
  parameter int DIGITS     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_timer,
  input  logic                stop_n,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  // Input conditioning: two-flop synchronisers plus a previous-value register
  // for edge detection. Stop idles high, start idles low.
  logic stop_meta, stop_sync, stop_prev;
  logic start_meta, start_sync, start_prev;
  logic press_ev, start_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_meta  <= 1'b1;
      stop_sync  <= 1'b1;
      stop_prev  <= 1'b1;
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      stop_meta  <= stop_n;
      stop_sync  <= stop_meta;
      stop_prev  <= stop_sync;
      start_meta <= start_timer;
      start_sync <= start_meta;
      start_prev <= start_sync;
    end
  end

  assign press_ev = stop_prev & ~stop_sync;
  assign start_ev = start_sync & ~start_prev;

  // Millisecond prescaler, only advances in RUN and sits at 0 otherwise, so a
  // new run always starts a full millisecond from the start event.
  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          ms_tick;

  assign ms_tick = (presc == PW'(CLK_PER_MS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (state != RUN || ms_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Decade chain. The digits may roll to all-zero on the saturating tick;
  // the output mux below shows all-9s while overflow is set, and the digits
  // are cleared anyway on the next start.
  logic                inc_ms;
  logic                clr;
  logic                sat;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   co;
  logic [4*DIGITS-1:0] digits;

  assign inc_ms   = (state == RUN) & ms_tick;
  assign carry[0] = inc_ms;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (carry[i]),
      .q     (digits[4*i +: 4]),
      .co    (co[i])
    );
    if (i < DIGITS - 1) begin : g_carry
      assign carry[i+1] = co[i];
    end
  end

  // Every digit carrying out means the count was MAX_MS and just ticked again.
  assign sat = &co;

  // FSM
  logic done_nxt;
  logic ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ovf_set   = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, HOLD: begin
        // Start beats a simultaneous press; the press is simply not looked at.
        if (start_ev) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        // A press on a tick cycle still takes that tick, since inc_ms is
        // independent of the press.
        if (sat) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
          ovf_set   = 1'b1;
        end else if (press_ev) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= done_nxt;
      if (clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign bcd  = overflow ? {DIGITS{BCD_NINE}} : digits;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

  localparam int CPM    = 4;
  localparam int DIG    = 4;
  localparam int MAX_MS = 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_timer;
  logic        stop_n;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  reaction_timer #(.CLK_PER_MS(CPM), .DIGITS(DIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_timer (start_timer),
    .stop_n      (stop_n),
    .bcd         (bcd),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int ms);
    logic [15:0] r;
    int v;
    r = '0;
    v = ms;
    for (int d = 0; d < DIG; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: start pin to press pin separated by n cycles yields n/CPM ms,
  // saturating at MAX_MS with overflow.
  function automatic exp_t model(input int n_cycles);
    exp_t e;
    int ms;
    ms = n_cycles / CPM;
    e.ovf = (ms > MAX_MS);
    e.bcd = to_bcd(e.ovf ? MAX_MS : ms);
    return e;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("done_busy_exclusive", 32'(done & busy), 32'd0);
      for (int d = 0; d < DIG; d++)
        check("digit_range", 32'(bcd[4*d +: 4] > 4'd9), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 bcd=%04h, expected no done at %0t", bcd, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_bcd", 32'(bcd), 32'(e.bcd));
          check("result_ovf", 32'(overflow), 32'(e.ovf));
          check("result_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse, then press n cycles after the start pin rose (n >= 2).
  task automatic measure(input int n);
    start_timer = 1'b1;
    tick(1);
    start_timer = 1'b0;
    tick(n - 1);
    stop_n = 1'b0;
    sb.push_back(model(n));
    tick(5);
    stop_n = 1'b1;
    tick(5);
    check("done_arrived", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    rst_n       = 1'b0;
    start_timer = 1'b0;
    stop_n      = 1'b1;
    tick(3);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Press in IDLE: no done, nothing changes.
    stop_n = 1'b0;
    tick(6);
    stop_n = 1'b1;
    tick(4);
    check("idle_press_bcd", 32'(bcd), 32'd0);
    check("idle_press_busy", 32'(busy), 32'd0);

    // Reset mid-run.
    start_timer = 1'b1;
    tick(1);
    start_timer = 1'b0;
    tick(30);
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_bcd", 32'(bcd), 32'd0);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_ovf", 32'(overflow), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_bcd", 32'(bcd), 32'd0);

    // Basic measurement and hold.
    measure(43);
    held = bcd;
    tick(100);
    check("hold_bcd", 32'(bcd), 32'h0010);
    check("hold_stable", 32'(bcd), 32'(held));
    check("hold_busy", 32'(busy), 32'd0);

    // Press in HOLD is ignored.
    stop_n = 1'b0;
    tick(6);
    stop_n = 1'b1;
    tick(4);
    check("hold_press_bcd", 32'(bcd), 32'h0010);

    // Boundary around the 0x0009 -> 0x0010 increment.
    measure(39);
    measure(40);
    check("boundary_bcd", 32'(bcd), 32'h0010);

    // Carry chain.
    measure(4 * 1000);
    check("carry_1000", 32'(bcd), 32'h1000);
    measure(4 * 199);
    check("carry_0199", 32'(bcd), 32'h0199);

    // Start edge during RUN does not restart the count.
    start_timer = 1'b1;
    tick(1);
    start_timer = 1'b0;
    tick(20);
    start_timer = 1'b1;
    tick(2);
    start_timer = 1'b0;
    tick(37);
    stop_n = 1'b0;
    sb.push_back(model(60));
    tick(5);
    stop_n = 1'b1;
    tick(5);
    check("rerun_start_done", 32'(sb.size()), 32'd0);

    // Start and press together in HOLD: start wins, press dropped.
    start_timer = 1'b1;
    stop_n      = 1'b0;
    tick(1);
    start_timer = 1'b0;
    tick(3);
    check("simul_busy", 32'(busy), 32'd1);
    check("simul_bcd", 32'(bcd), 32'd0);
    tick(1);
    stop_n = 1'b1;
    tick(30);
    stop_n = 1'b0;
    sb.push_back(model(35));
    tick(5);
    stop_n = 1'b1;
    tick(5);
    check("simul_done", 32'(sb.size()), 32'd0);

    // Randomised runs.
    for (int k = 0; k < 10; k++) begin
      measure(int'($urandom_range(2, 300)));
    end

    // Overflow.
    start_timer = 1'b1;
    tick(1);
    start_timer = 1'b0;
    sb.push_back(model(4 * 10000));
    tick(4 * 10000 + 9);
    check("ovf_done", 32'(sb.size()), 32'd0);
    check("ovf_bcd", 32'(bcd), 32'h9999);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    tick(50);
    check("ovf_no_wrap", 32'(bcd), 32'h9999);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Next start clears overflow and bcd.
    start_timer = 1'b1;
    tick(1);
    start_timer = 1'b0;
    tick(3);
    check("restart_ovf", 32'(overflow), 32'd0);
    check("restart_bcd", 32'(bcd), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    tick(4);
    stop_n = 1'b0;
    sb.push_back(model(8));
    tick(5);
    stop_n = 1'b1;
    tick(5);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream stage of the lights/delay FSM; consumes its start_timer output.
- Measures the player's reaction time in milliseconds, from the start_timer rising edge to the press of the stop key.
- Holds the result as 4-digit BCD for the seven-segment display driver.
- Flags overflow: no press before MAX_MS.

Parameters:
- CLK_PER_MS, 50000, clk cycles per millisecond (50 MHz board clock); sims use 4
- DIGITS, 4, number of BCD decades; MAX_MS = 10^DIGITS - 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_timer  in  1  level from FSM, high for one tick period; only its rising edge acts
- stop_n  in  1  raw push-button, active-low, asynchronous to clk
- bcd  out  4*DIGITS  result, digit 0 = ms units in [3:0]
- busy  out  1  high while measuring
- done  out  1  one-cycle pulse when a measurement ends (press or overflow)
- overflow  out  1  sticky until next start; set when MAX_MS is exceeded

Behaviour:
- Reset: rst_n low forces the following immediately, including mid-RUN; no partial result kept.
  - state IDLE, bcd 0, busy 0, done 0, overflow 0
  - prescaler 0, synchronisers and edge registers cleared to their inactive levels (stop sync = 1)
- Input conditioning:
  - stop_n passes through a 2-flop synchroniser; a press event = synchronised value 1 to 0.
  - start_timer passes through a 2-flop synchroniser; a start event = synchronised value 0 to 1.
  - Latency from pin to event is 3 clk.
- State IDLE:
  - start event -> RUN; bcd cleared, prescaler cleared, overflow cleared, busy 1 from next cycle.
  - Press ignored.
- State RUN:
  - Prescaler counts 0..CLK_PER_MS-1 and wraps. At the cycle where it equals CLK_PER_MS-1, bcd increments by 1 ms.
  - BCD increment: decimal ripple carry, each digit wraps 9 to 0 and carries into the next.
  - Press event -> HOLD, busy 0, done 1 for exactly one cycle.
  - Press in the same cycle as an increment: the increment is applied and included in the held result.
  - Increment when bcd = MAX_MS (all 9s) -> HOLD, bcd stays MAX_MS (no wrap to 0), overflow 1, done 1 for one cycle.
  - Start event during RUN: ignored.
- State HOLD:
  - bcd, overflow held.
  - Press ignored.
  - Start event -> RUN exactly as from IDLE: restart, overflow cleared.
- Simultaneous start and press events in IDLE/HOLD: start wins, press dropped.
- done never asserts in IDLE; done and busy never high together.
- bcd never contains a digit > 9.

Decomposition:
- Shared header/package:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2; 2'd3 unreachable, recovers to IDLE
  - default CLK_PER_MS, so the FSM delay timer and this block agree on the ms tick
- Sub-module bcd_digit: one decade counter.
  - Ports: clk, rst_n, clr, inc (carry in), q[3:0], co.
  - co = inc & (q==9).
  - Instantiated DIGITS times in a generate loop.
- Saturation detect: AND of all digit co outputs.

Test Plan:
- Reset mid-run: CLK_PER_MS=4, start, wait 30 clk, pulse rst_n low 1 clk -> bcd=0x0000, busy=0, state IDLE; no done pulse.
- Basic measure: start rising edge, press 40 clk after busy rises -> bcd=0x0010, done one cycle, busy 0, value held 100 clk.
- Carry chain: press after 4*1000 clk -> bcd=0x1000; then 4*(199) more in a new run -> bcd=0x0199, no invalid digits.
- Overflow: start, no press for 4*10000+10 clk -> bcd=0x9999, overflow=1, done single pulse, bcd does not wrap; next start clears overflow and bcd.
- Ignored events: press in IDLE and HOLD leaves bcd unchanged and no done; start edge during RUN does not restart the count; start and press in the same cycle in HOLD -> RUN with bcd=0.
- Boundary press: press event on the exact increment cycle at count 0x0009 -> held bcd=0x0010.
